// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M-style multiply/divide unit. Iterative shift-add multiply and restoring divide.
// Latency: XLEN edges after accept for iterative ops; divide-by-zero/overflow (and multiplies
//   when MULDIV_FAST_MUL_EN is defined) complete on the accepting edge.
// Backpressure: startReady only in IDLE; the result is held in DONE until resultReady.
// Ports: clock/reset (async, active-high); startValid/startReady/op/operand1/operand2/
//   destinationRegister = request; resultValid/resultReady/result/resultDestination = response;
//   flush kills any in-flight op; busy = stall request while not IDLE.
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle multiplier (MUL state unused).
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            startValid,
   output logic            startReady,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   input  logic [4:0]      destinationRegister,
   input  logic            flush,
   output logic            resultValid,
   input  logic            resultReady,
   output logic [XLEN-1:0] result,
   output logic [4:0]      resultDestination,
   output logic            busy
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t            state_q;
   logic [CW-1:0]     cnt_q;
   // MUL: {partial product, multiplier}. DIV: {remainder, dividend shifting into quotient}.
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opb_q;      // multiplicand / divisor magnitude
   logic [2:0]        op_q;
   logic              neg_q;      // negate product or quotient at the end
   logic              negr_q;     // negate remainder at the end
   logic [XLEN-1:0]   result_q;
   logic [4:0]        rd_q;

   // Operand signedness by op: MUL/MULH both signed, MULHSU rs1 only, MULHU none;
   // DIV/REM signed, DIVU/REMU unsigned. MUL low half is sign-agnostic.
   logic            s1, s2, neg1, neg2;
   logic [XLEN-1:0] mag1, mag2;
   assign s1   = op[2] ? ~op[0] : (op[1:0] != 2'd3);
   assign s2   = op[2] ? ~op[0] : ~op[1];
   assign neg1 = s1 & operand1[XLEN-1];
   assign neg2 = s2 & operand2[XLEN-1];
   assign mag1 = neg1 ? -operand1 : operand1;
   assign mag2 = neg2 ? -operand2 : operand2;

`ifdef MULDIV_FAST_MUL_EN
   // Sign-extend per op, then a modulo-2^(2*XLEN) multiply gives the exact signed product.
   logic [2*XLEN-1:0] ext1, ext2, fast_prod;
   assign ext1      = {{XLEN{neg1}}, operand1};
   assign ext2      = {{XLEN{neg2}}, operand2};
   assign fast_prod = ext1 * ext2;
`endif

   // One iteration step plus the sign-corrected final result of that step.
   logic [XLEN:0]     mul_sum, rem_sh, rem_sub;
   logic [2*XLEN-1:0] prod_fin;
   logic [XLEN-1:0]   quo_fin, rem_fin, iter_res;
   always_comb begin
      mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
      rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      // Remainder < divisor keeps this difference inside XLEN+1 signed bits.
      rem_sub = rem_sh - {1'b0, opb_q};
      acc_d   = acc_q;
      if (state_q == S_MUL)
         acc_d = {mul_sum, acc_q[XLEN-1:1]};
      else if (!rem_sub[XLEN])
         acc_d = {rem_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
         acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      prod_fin = neg_q  ? -acc_d : acc_d;
      quo_fin  = neg_q  ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
      rem_fin  = negr_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
      if (state_q == S_MUL)
         iter_res = (op_q == 3'd0) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
      else
         iter_res = op_q[1] ? rem_fin : quo_fin;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         negr_q   <= 1'b0;
         result_q <= '0;
         rd_q     <= '0;
      end else if (flush) begin
         // Flush wins over a simultaneous start or result handshake.
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (startValid) begin
                  op_q   <= op;
                  rd_q   <= destinationRegister;
                  cnt_q  <= '0;
                  neg_q  <= neg1 ^ neg2;
                  negr_q <= neg1;
                  if (!op[2]) begin
`ifdef MULDIV_FAST_MUL_EN
                     result_q <= (op == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
                     state_q  <= S_DONE;
`else
                     acc_q   <= {{XLEN{1'b0}}, mag2};
                     opb_q   <= mag1;
                     state_q <= S_MUL;
`endif
                  end else if (operand2 == '0) begin
                     result_q <= op[1] ? operand1 : '1;
                     state_q  <= S_DONE;
                  end else if (!op[0] && operand1 == MOST_NEG && operand2 == '1) begin
                     result_q <= op[1] ? '0 : operand1;
                     state_q  <= S_DONE;
                  end else begin
                     acc_q   <= {{XLEN{1'b0}}, mag1};
                     opb_q   <= mag2;
                     state_q <= S_DIV;
                  end
               end
            end
            S_MUL, S_DIV: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_STEP) begin
                  result_q <= iter_res;
                  state_q  <= S_DONE;
               end
            end
            S_DONE: begin
               if (resultReady)
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign startReady        = (state_q == S_IDLE);
   assign busy              = (state_q != S_IDLE);
   assign resultValid       = (state_q == S_DONE);
   assign result            = result_q;
   assign resultDestination = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit (XLEN=32): directed vectors plus randomized ops against a
// 64-bit arithmetic reference model; latency counted in edges after the accepting edge.
module tb_muldiv_unit;
   localparam int XLEN = 32;
   localparam logic [31:0] MOST_NEG = 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 0;
`else
   localparam int MUL_LAT = 32;
`endif
   localparam int DIV_LAT = 32;

   logic        clock, reset, startValid, startReady, flush, resultValid, resultReady, busy;
   logic [2:0]  op;
   logic [31:0] operand1, operand2, result;
   logic [4:0]  destinationRegister, resultDestination;

   int vectors = 0;
   int miscompares = 0;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clock(clock), .reset(reset), .startValid(startValid), .startReady(startReady),
      .op(op), .operand1(operand1), .operand2(operand2),
      .destinationRegister(destinationRegister), .flush(flush),
      .resultValid(resultValid), .resultReady(resultReady), .result(result),
      .resultDestination(resultDestination), .busy(busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: plain 64-bit arithmetic straight from the op definitions.
   function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub, q;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a);
      ub = longint'(b);
      p  = '0;
      case (o)
         3'd0: p = ua * ub;
         3'd1: p = sa * sb;
         3'd2: p = sa * ub;
         3'd3: p = ua * ub;
         default: p = '0;
      endcase
      case (o)
         3'd0: return p[31:0];
         3'd1, 3'd2, 3'd3: return p[63:32];
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MOST_NEG && b == 32'hFFFF_FFFF) return a;
            q = sa / sb; p = q; return p[31:0];
         end
         3'd5: begin
            if (b == 0) return 32'hFFFF_FFFF;
            q = ua / ub; p = q; return p[31:0];
         end
         3'd6: begin
            if (b == 0) return a;
            if (a == MOST_NEG && b == 32'hFFFF_FFFF) return 32'h0;
            q = sa % sb; p = q; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            q = ua % ub; p = q; return p[31:0];
         end
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (!o[2]) return MUL_LAT;
      if (b == 0) return 0;
      if (!o[0] && a == MOST_NEG && b == 32'hFFFF_FFFF) return 0;
      return DIV_LAT;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return MOST_NEG;
         3: return 32'd1;
         4: return 32'($urandom_range(0, 255));
         default: return $urandom;
      endcase
   endfunction

   // Called one time unit after a posedge with the unit idle; returns when resultValid
   // is seen or the budget runs out. Inputs are scrambled after the accept edge.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat);
      startValid = 1'b1; op = o; operand1 = a; operand2 = b; destinationRegister = rd;
      @(posedge clock); #1;
      startValid = 1'b0; op = 3'($urandom); operand1 = $urandom; operand2 = $urandom;
      destinationRegister = 5'($urandom);
      lat = 0;
      while (!resultValid && lat < 100) begin
         @(posedge clock); #1;
         lat++;
      end
      res = result;
      rdo = resultDestination;
   endtask

   task automatic retire();
      resultReady = 1'b1;
      @(posedge clock); #1;
      resultReady = 1'b0;
      if (busy) begin
         flush = 1'b1;
         @(posedge clock); #1;
         flush = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; startValid = 1'b0; resultReady = 1'b0; flush = 1'b0;
      op = '0; operand1 = '0; operand2 = '0; destinationRegister = '0;
      #3;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
      vectors++; if (resultValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", resultValid); end
      vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h want 0", result); end
      vectors++; if (resultDestination !== 5'd0) begin miscompares++; $display("FAIL reset_rd got %h want 0", resultDestination); end
      vectors++; if (startReady !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", startReady); end
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic test_mul_directed();
      logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
      logic [31:0] as  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
      logic [31:0] exp [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      logic [31:0] res; logic [4:0] rdo; int lat;
      for (int i = 0; i < 4; i++) begin
         do_op(ops[i], as[i], bs[i], 5'(i + 3), res, rdo, lat);
         vectors++; if (res !== exp[i]) begin miscompares++; $display("FAIL mul_dir[%0d] result got %h want %h", i, res, exp[i]); end
         vectors++; if (lat !== MUL_LAT) begin miscompares++; $display("FAIL mul_dir[%0d] latency got %0d want %0d", i, lat, MUL_LAT); end
         vectors++; if (rdo !== 5'(i + 3)) begin miscompares++; $display("FAIL mul_dir[%0d] rd got %0d want %0d", i, rdo, i + 3); end
         retire();
      end
   endtask

   task automatic test_div_directed();
      logic [2:0]  ops [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
      logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] exp [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      int          elat[6] = '{32, 32, 0, 0, 0, 0};
      logic [31:0] res; logic [4:0] rdo; int lat;
      for (int i = 0; i < 6; i++) begin
         do_op(ops[i], as[i], bs[i], 5'(20 + i), res, rdo, lat);
         vectors++; if (res !== exp[i]) begin miscompares++; $display("FAIL div_dir[%0d] result got %h want %h", i, res, exp[i]); end
         vectors++; if (lat !== elat[i]) begin miscompares++; $display("FAIL div_dir[%0d] latency got %0d want %0d", i, lat, elat[i]); end
         retire();
      end
   endtask

   task automatic test_flush();
      logic [31:0] res; logic [4:0] rdo; int lat; int seen;
      startValid = 1'b1; op = 3'd4; operand1 = 32'd1000; operand2 = 32'd3; destinationRegister = 5'd4;
      @(posedge clock); #1;
      startValid = 1'b0;
      repeat (9) @(posedge clock);
      #1 flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      vectors++; if (startReady !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b want 1", startReady); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_busy got %b want 0", busy); end
      seen = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (resultValid) seen++;
      end
      vectors++; if (seen !== 0) begin miscompares++; $display("FAIL flush_novalid got %0d valid cycles want 0", seen); end
      do_op(3'd5, 32'd100, 32'd7, 5'd11, res, rdo, lat);
      vectors++; if (res !== 32'd14) begin miscompares++; $display("FAIL flush_follow result got %h want %h", res, 32'd14); end
      vectors++; if (rdo !== 5'd11) begin miscompares++; $display("FAIL flush_follow rd got %0d want 11", rdo); end
      retire();
      // A start that coincides with flush is dropped.
      startValid = 1'b1; flush = 1'b1; op = 3'd5; operand1 = 32'd9; operand2 = 32'd2;
      @(posedge clock); #1;
      startValid = 1'b0; flush = 1'b0;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_vs_start busy got %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      logic [31:0] res; logic [4:0] rdo; int lat;
      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, res, rdo, lat);
      for (int i = 0; i < 5; i++) begin
         startValid = 1'b1; op = 3'd5; operand1 = $urandom; operand2 = 32'd3; destinationRegister = 5'd30;
         @(posedge clock); #1;
         vectors++; if (resultValid !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d] got %b want 1", i, resultValid); end
         vectors++; if (result !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL bp_result[%0d] got %h want ffffffeb", i, result); end
         vectors++; if (resultDestination !== 5'd9) begin miscompares++; $display("FAIL bp_rd[%0d] got %0d want 9", i, resultDestination); end
         vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy[%0d] got %b want 1", i, busy); end
         vectors++; if (startReady !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d] got %b want 0", i, startReady); end
      end
      // startValid stays high across the DONE->IDLE edge and must not be taken.
      resultReady = 1'b1;
      @(posedge clock); #1;
      resultReady = 1'b0; startValid = 1'b0;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_release busy got %b want 0", busy); end
      vectors++; if (resultValid !== 1'b0) begin miscompares++; $display("FAIL bp_release valid got %b want 0", resultValid); end
   endtask

   task automatic test_reset_midop();
      int seen;
      startValid = 1'b1; op = 3'd6; operand1 = 32'd12345; operand2 = 32'd17; destinationRegister = 5'd7;
      @(posedge clock); #1;
      startValid = 1'b0;
      repeat (5) @(posedge clock);
      #3 reset = 1'b1;
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid busy got %b want 0", busy); end
      vectors++; if (startReady !== 1'b1) begin miscompares++; $display("FAIL rst_mid ready got %b want 1", startReady); end
      vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL rst_mid result got %h want 0", result); end
      @(posedge clock); #1 reset = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (resultValid) seen++;
      end
      vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rst_mid novalid got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_random();
      logic [2:0] o; logic [31:0] a, b, res; logic [4:0] rd, rdo; int lat;
      for (int i = 0; i < 150; i++) begin
         o  = 3'($urandom);
         a  = rand_operand();
         b  = rand_operand();
         rd = 5'($urandom);
         do_op(o, a, b, rd, res, rdo, lat);
         vectors++; if (res !== ref_result(o, a, b)) begin miscompares++; $display("FAIL rand[%0d] op%0d %h,%h result got %h want %h", i, o, a, b, res, ref_result(o, a, b)); end
         vectors++; if (lat !== ref_latency(o, a, b)) begin miscompares++; $display("FAIL rand[%0d] op%0d latency got %0d want %0d", i, o, lat, ref_latency(o, a, b)); end
         vectors++; if (rdo !== rd) begin miscompares++; $display("FAIL rand[%0d] rd got %0d want %0d", i, rdo, rd); end
         retire();
      end
   endtask

   initial begin
      test_reset();
      test_mul_directed();
      test_div_directed();
      test_flush();
      test_backpressure();
      test_reset_midop();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; even, >= 8.
REQ-002 SHALL have port clock  input  1  single clock, all state on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high.
REQ-004 SHALL have port startValid  input  1  operation request from execute stage.
REQ-005 SHALL have port startReady  output  1  unit can accept; high only in IDLE.
REQ-006 SHALL have port op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port operand1  input  XLEN  rs1 value, already forwarded.
REQ-008 SHALL have port operand2  input  XLEN  rs2 value, already forwarded.
REQ-009 SHALL have port destinationRegister  input  5  rd tag, carried with the op.
REQ-010 SHALL have port flush  input  1  pipeline flush; kills any in-flight op.
REQ-011 SHALL have port resultValid  output  1  result available.
REQ-012 SHALL have port resultReady  input  1  consumer accepts result.
REQ-013 SHALL have port result  output  XLEN  operation result.
REQ-014 SHALL have port resultDestination  output  5  rd tag of result.
REQ-015 SHALL have port busy  output  1  stall request to pipeline; high whenever state != IDLE.

Function
REQ-016 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-017 SHALL accept on an edge where startValid && startReady && !flush; operands, op and rd latched on that edge.
REQ-018 SHALL go IDLE->MUL (ops 0-3) or IDLE->DIV (ops 4-7) on accept; count starts at 0, width clog2(XLEN)+1.
REQ-019 SHALL do MUL as XLEN-step shift-add on operand magnitudes into a 2*XLEN product, negating it at the end when the signs (per op signedness) differ.
REQ-020 SHALL do DIV as XLEN-step restoring division on magnitudes; quotient sign = sign1 XOR sign2, remainder sign = dividend sign (signed ops only).
REQ-021 SHALL enter DONE exactly XLEN edges after the accepting edge for iterative ops.
REQ-022 SHALL select MUL: product[XLEN-1:0]; MULH/MULHSU/MULHU: product[2*XLEN-1:XLEN].
REQ-023 SHALL handle divide by zero in one edge: quotient all ones, remainder = operand1, skipping iteration.
REQ-024 SHALL handle signed overflow (operand1 = most negative, operand2 = -1) in one edge: quotient = operand1, remainder 0.
REQ-025 SHALL hold resultValid, result and resultDestination stable in DONE until resultValid && resultReady, then go to IDLE on that edge.
REQ-026 SHALL not accept a new op in the DONE->IDLE cycle (startReady low in DONE).
REQ-027 SHALL go to IDLE from any state on a flush edge, dropping resultValid; flush beats a simultaneous start or handshake.
REQ-028 SHALL zero-extend nothing: all arithmetic exactly XLEN / 2*XLEN bits, wrap-around modulo 2^XLEN.

Reset
REQ-029 SHALL on reset assertion, asynchronously: state IDLE, count 0, resultValid 0, result 0, resultDestination 0, busy 0; startReady 1 once in IDLE.
REQ-030 SHALL abandon any in-flight op when reset is asserted mid-operation; no result is produced.

Configuration
REQ-031 SHALL, with MULDIV_FAST_MUL_EN defined, compute ops 0-3 with a single-cycle 2*XLEN multiplier, IDLE->DONE in one edge, MUL state unused.
REQ-032 SHALL, without MULDIV_FAST_MUL_EN, use the iterative XLEN-edge multiplier; divide behaviour identical in both builds.

Verification (XLEN=32)
REQ-033 SHALL check MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB, resultValid 32 edges after accept (1 edge with MULDIV_FAST_MUL_EN).
REQ-034 SHALL check MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-035 SHALL check DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, each 32 edges latency.
REQ-036 SHALL check DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, each 1 edge latency.
REQ-037 SHALL check flush at edge 10 of a DIV -> resultValid never asserts, startReady high next cycle, following DIVU 100/7 -> 14.
REQ-038 SHALL check resultReady low 5 cycles in DONE -> result, resultDestination stable, busy high, startValid ignored.
